demux2_queued: RTL and testbench
================================

# demux2_queued

Sequential counterpart of the 2:1 mux: a 1-to-2 stream demultiplexer. It accepts one message per cycle on a val/rdy input port and steers each message, by a per-message select bit, into one of two independently flow-controlled val/rdy output ports. Each output is decoupled by a 2-entry queue, so a stalled output does not block traffic to the other. It sits between a single producer and two consumers, for example a request splitter in front of two memory banks.

## Interface
- p_nbits, 8, message payload width (≥1)
- p_cnt_nbits, 16, width of per-output delivered-message counters
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_val  in  1  input message valid
- in_rdy  out  1  input ready
- in_msg  in  p_nbits  input payload
- in_sel  in  1  destination: 0 → out0, 1 → out1
- out0_val / out1_val  out  1  output valid
- out0_rdy / out1_rdy  in  1  output ready
- out0_msg / out1_msg  out  p_nbits  output payload
- out0_count / out1_count  out  p_cnt_nbits  messages delivered on that output since reset

## Operation
- Input transfer occurs on posedge when in_val && in_rdy. The message is written into queue[in_sel]. It never goes to both queues and is never dropped.
- in_rdy = ~reset && (in_sel ? ~full1 : ~full0). in_rdy depends only on in_sel and queue occupancy, never on out*_rdy, so there is no combinational rdy→rdy path.
- Each queue is a 2-entry FIFO with occupancy 0..2 and 1-bit head/tail pointers. Pointers wrap 1→0.
- Enqueue and dequeue in the same cycle:
  - occupancy 1: occupancy stays 1.
  - occupancy 2: enqueue is already blocked by full, so dequeue alone takes occupancy to 1.
  - occupancy 0: only enqueue is possible (no bypass), so occupancy becomes 1.
- outN_val = (occupancyN != 0). outN_msg = head entry. outN_msg is don't-care when outN_val = 0, but must hold stable while outN_val && !outN_rdy.
- Output transfer on posedge when outN_val && outN_rdy: the head advances and outN_count increments modulo 2^p_cnt_nbits (wraps all-ones → 0).
- Ordering: messages to the same output leave in arrival order. There is no ordering guarantee between out0 and out1.
- Reset (async, active-high), effective immediately and mid-transfer:
  - occupancies 0, pointers 0, counters 0
  - out0_val = out1_val = 0, in_rdy = 0 while reset is high
  - in-flight messages are discarded
  - after reset deasserts, in_rdy = 1 on the first cycle

## Timing
- Latency from input accept to outN_val is 1 cycle (registered, no bypass).
- Throughput is 1 msg/cycle per output with constant outN_rdy = 1. Total input throughput is 1 msg/cycle in any select pattern.
- Backpressure: with outN_rdy held 0, exactly 2 messages are accepted for output N. in_rdy then drops whenever in_sel = N, while traffic with in_sel = ~N continues.
- Counter update is visible the cycle after the output transfer.

## Structure
- Package demux2_pkg:
  - localparam c_qdepth = 2
  - typedef for occupancy (2-bit)
  - typedef enum for select (SEL_OUT0 = 0, SEL_OUT1 = 1)
- Sub-module demux2_queue2: a parameterized 2-entry normal queue with enq/deq val/rdy and an occupancy output. It is instantiated twice. The top level holds the steering logic and counters.
- All flops use async active-high reset on clk.

## Test plan
- Basic steering: send 0xA1 with sel=0, then 0xB2 with sel=1, both outputs rdy=1 → out0 shows 0xA1 one cycle after its accept, out1 shows 0xB2 one cycle later; both counts = 1.
- Full-rate alternation: 8 messages 0x00..0x07 with alternating sel, outputs always ready → in_rdy stays 1 throughout; out0 delivers 00,02,04,06 and out1 delivers 01,03,05,07 in order.
- Isolation under stall: out0_rdy=0, send 0x10, 0x11 (sel=0), then a sel=0 request 0x12 → in_rdy=0 for 0x12. Switch to sel=1 messages 0x20, 0x21 → accepted and delivered on out1. Raise out0_rdy → 0x10, 0x11, 0x12 delivered in order.
- Full with simultaneous dequeue: queue0 holds 2 entries, out0_rdy=1 and a sel=0 request in the same cycle → in_rdy=0 that cycle. Occupancy goes to 1 and the request is accepted on the next cycle.
- Counter wrap: with p_cnt_nbits=3, deliver 9 messages on out1 → out1_count reads 1 and out0_count stays 0.
- Async reset mid-operation: queue0 holds 2 entries and queue1 holds 1, then pulse reset between clock edges → out0_val, out1_val, in_rdy and both counts go to 0 immediately without a clock edge. After release, a new message 0x5A (sel=1) is the first output on out1.

Source files
------------

// File: rtl/demux2_pkg.sv
// Shared types and constants for the queued 1-to-2 stream demultiplexer.
package demux2_pkg;

  localparam int unsigned c_qdepth = 2;

  typedef logic [1:0] occ_t;

  typedef enum logic {
    SEL_OUT0 = 1'b0,
    SEL_OUT1 = 1'b1
  } sel_e;

endpackage

// File: rtl/demux2_queue2.sv
// Two-entry normal queue with val/rdy on both sides; no bypass, so data is visible one cycle
// after enqueue.
module demux2_queue2
  import demux2_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [Width-1:0] enq_msg_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [Width-1:0] deq_msg_o,
  output occ_t             occ_o
);

  logic [Width-1:0] mem_q [c_qdepth];
  logic [Width-1:0] mem_d [c_qdepth];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             enq_fire;
  logic             deq_fire;

  // Ready depends only on occupancy, so a simultaneous dequeue never frees a full slot early.
  always_comb begin
    enq_rdy_o = (occ_q != occ_t'(c_qdepth));
    deq_val_o = (occ_q != '0);
    deq_msg_o = mem_q[head_q];
    occ_o     = occ_q;
    enq_fire  = enq_val_i && enq_rdy_o;
    deq_fire  = deq_val_o && deq_rdy_i;
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (enq_fire) begin
      mem_d[tail_q] = enq_msg_i;
      tail_d        = ~tail_q;
    end
    if (deq_fire) begin
      head_d = ~head_q;
    end
    unique case ({enq_fire, deq_fire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/demux2_queued.sv
// 1-to-2 stream demultiplexer: steers each input message by in_sel into one of two
// independently flow-controlled queued outputs, and counts deliveries per output.
module demux2_queued
  import demux2_pkg::*;
#(
  parameter int unsigned p_nbits     = 8,
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_nbits-1:0]     in_msg,
  input  logic                   in_sel,
  output logic                   out0_val,
  input  logic                   out0_rdy,
  output logic [p_nbits-1:0]     out0_msg,
  output logic [p_cnt_nbits-1:0] out0_count,
  output logic                   out1_val,
  input  logic                   out1_rdy,
  output logic [p_nbits-1:0]     out1_msg,
  output logic [p_cnt_nbits-1:0] out1_count
);

  sel_e                   sel;
  logic                   enq_val0, enq_val1;
  logic                   enq_rdy0, enq_rdy1;
  logic                   deq_val0, deq_val1;
  occ_t                   occ0, occ1;
  logic [p_cnt_nbits-1:0] cnt0_q, cnt0_d;
  logic [p_cnt_nbits-1:0] cnt1_q, cnt1_d;
  logic                   unused_occ;

  assign unused_occ = ^{occ0, occ1};

  // in_rdy looks only at the selected queue's occupancy: no combinational path from out*_rdy.
  always_comb begin
    sel      = sel_e'(in_sel);
    in_rdy   = ~reset && ((sel == SEL_OUT1) ? enq_rdy1 : enq_rdy0);
    enq_val0 = in_val && in_rdy && (sel == SEL_OUT0);
    enq_val1 = in_val && in_rdy && (sel == SEL_OUT1);
  end

  demux2_queue2 #(
    .Width (p_nbits)
  ) u_queue0 (
    .clk_i     (clk),
    .rst_i     (reset),
    .enq_val_i (enq_val0),
    .enq_rdy_o (enq_rdy0),
    .enq_msg_i (in_msg),
    .deq_val_o (deq_val0),
    .deq_rdy_i (out0_rdy),
    .deq_msg_o (out0_msg),
    .occ_o     (occ0)
  );

  demux2_queue2 #(
    .Width (p_nbits)
  ) u_queue1 (
    .clk_i     (clk),
    .rst_i     (reset),
    .enq_val_i (enq_val1),
    .enq_rdy_o (enq_rdy1),
    .enq_msg_i (in_msg),
    .deq_val_o (deq_val1),
    .deq_rdy_i (out1_rdy),
    .deq_msg_o (out1_msg),
    .occ_o     (occ1)
  );

  always_comb begin
    out0_val   = deq_val0;
    out1_val   = deq_val1;
    out0_count = cnt0_q;
    out1_count = cnt1_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (deq_val0 && out0_rdy) begin
      cnt0_d = cnt0_q + p_cnt_nbits'(1);
    end
    if (deq_val1 && out1_rdy) begin
      cnt1_d = cnt1_q + p_cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_demux2_queued.sv
// Bench for demux2_queued: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional async resets.
module tb_demux2_queued;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val, in_sel, out0_rdy, out1_rdy;
  logic [7:0] in_msg;

  logic        in_rdy, out0_val, out1_val;
  logic [7:0]  out0_msg, out1_msg;
  logic [15:0] out0_count, out1_count;

  logic       w_in_rdy, w_out0_val, w_out1_val;
  logic [7:0] w_out0_msg, w_out1_msg;
  logic [2:0] w_out0_count, w_out1_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  q0[$], q1[$];
  logic [7:0]  got0[$], got1[$];
  int unsigned cnt0, cnt1;
  logic        m_acc, m_d0, m_d1;

  demux2_queued #(.p_nbits(8), .p_cnt_nbits(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .in_sel     (in_sel),
    .out0_val   (out0_val),
    .out0_rdy   (out0_rdy),
    .out0_msg   (out0_msg),
    .out0_count (out0_count),
    .out1_val   (out1_val),
    .out1_rdy   (out1_rdy),
    .out1_msg   (out1_msg),
    .out1_count (out1_count)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise counter wrap.
  demux2_queued #(.p_nbits(8), .p_cnt_nbits(3)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (w_in_rdy),
    .in_msg     (in_msg),
    .in_sel     (in_sel),
    .out0_val   (w_out0_val),
    .out0_rdy   (out0_rdy),
    .out0_msg   (w_out0_msg),
    .out0_count (w_out0_count),
    .out1_val   (w_out1_val),
    .out1_rdy   (out1_rdy),
    .out1_msg   (w_out1_msg),
    .out1_count (w_out1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rdy();
    return !reset && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
  endfunction

  // Reference model: two bounded FIFOs plus delivery counts.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      m_acc = in_val && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
      m_d0  = (q0.size() > 0) && out0_rdy;
      m_d1  = (q1.size() > 0) && out1_rdy;
      if (m_d0) begin
        void'(q0.pop_front());
        cnt0++;
      end
      if (m_d1) begin
        void'(q1.pop_front());
        cnt1++;
      end
      if (m_acc) begin
        if (in_sel) q1.push_back(in_msg);
        else        q0.push_back(in_msg);
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("in_rdy", in_rdy, exp_rdy());
    check("w_in_rdy", w_in_rdy, exp_rdy());
    check("out0_val", out0_val, q0.size() != 0);
    check("out1_val", out1_val, q1.size() != 0);
    check("w_out0_val", w_out0_val, q0.size() != 0);
    check("w_out1_val", w_out1_val, q1.size() != 0);
    if (q0.size() != 0) check("out0_msg", out0_msg, q0[0]);
    if (q1.size() != 0) check("out1_msg", out1_msg, q1[0]);
    check("out0_count", out0_count, cnt0 & 32'hffff);
    check("out1_count", out1_count, cnt1 & 32'hffff);
    check("w_out0_count", w_out0_count, cnt0 % 8);
    check("w_out1_count", w_out1_count, cnt1 % 8);
    if (!reset && out0_val && out0_rdy) got0.push_back(out0_msg);
    if (!reset && out1_val && out1_rdy) got1.push_back(out1_msg);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] m);
    in_val = v;
    in_sel = s;
    in_msg = m;
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out0_val", out0_val, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_rdy", in_rdy, 1);

    // Basic steering
    drive(1'b1, 1'b0, 8'hA1);
    cyc();
    drive(1'b1, 1'b1, 8'hB2);
    #1;
    check("basic_out0_val", out0_val, 1);
    check("basic_out0_msg", out0_msg, 8'hA1);
    check("basic_out1_val_early", out1_val, 0);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    #1;
    check("basic_out1_val", out1_val, 1);
    check("basic_out1_msg", out1_msg, 8'hB2);
    check("basic_out0_count", out0_count, 1);
    cyc();
    check("basic_out1_count", out1_count, 1);
    check("basic_out1_drained", out1_val, 0);

    // Full-rate alternation
    got0.delete();
    got1.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[0], 8'(i));
      #1;
      check("alt_in_rdy", in_rdy, 1);
      cyc();
    end
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) cyc();
    check("alt_got0_size", got0.size(), 4);
    check("alt_got1_size", got1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got0.size()) check("alt_got0", got0[k], 2 * k);
      if (k < got1.size()) check("alt_got1", got1[k], 2 * k + 1);
    end

    // Isolation under stall
    got0.delete();
    got1.delete();
    out0_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'h10);
    cyc();
    drive(1'b1, 1'b0, 8'h11);
    cyc();
    drive(1'b1, 1'b0, 8'h12);
    #1;
    check("stall_in_rdy_blocked", in_rdy, 0);
    cyc();
    check("stall_out0_msg_hold", out0_msg, 8'h10);
    drive(1'b1, 1'b1, 8'h20);
    #1;
    check("stall_other_in_rdy", in_rdy, 1);
    cyc();
    drive(1'b1, 1'b1, 8'h21);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) cyc();
    check("stall_got1_size", got1.size(), 2);
    if (got1.size() == 2) begin
      check("stall_got1_0", got1[0], 8'h20);
      check("stall_got1_1", got1[1], 8'h21);
    end
    check("stall_got0_none", got0.size(), 0);
    out0_rdy = 1'b1;
    drive(1'b1, 1'b0, 8'h12);
    #1;
    n = 0;
    while (!in_rdy && n < 10) begin
      cyc();
      n++;
    end
    check("stall_accept_bound", n < 10, 1);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    repeat (4) cyc();
    check("stall_got0_size", got0.size(), 3);
    if (got0.size() == 3) begin
      check("stall_got0_0", got0[0], 8'h10);
      check("stall_got0_1", got0[1], 8'h11);
      check("stall_got0_2", got0[2], 8'h12);
    end

    // Full queue with simultaneous dequeue
    out0_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'h30);
    cyc();
    drive(1'b1, 1'b0, 8'h31);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    out0_rdy = 1'b1;
    drive(1'b1, 1'b0, 8'h32);
    #1;
    check("fulldeq_in_rdy", in_rdy, 0);
    cyc();
    check("fulldeq_in_rdy_next", in_rdy, 1);
    check("fulldeq_head", out0_msg, 8'h31);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    #1;
    check("fulldeq_val", out0_val, 1);
    check("fulldeq_head2", out0_msg, 8'h32);
    repeat (2) cyc();

    // Counter wrap on the 3-bit instance
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + i));
      cyc();
    end
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) cyc();
    check("wrap_w_out1_count", w_out1_count, 1);
    check("wrap_w_out0_count", w_out0_count, 0);
    check("wrap_out1_count", out1_count, 9);

    // Async reset mid-operation
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'h50);
    cyc();
    drive(1'b1, 1'b0, 8'h51);
    cyc();
    drive(1'b1, 1'b1, 8'h52);
    cyc();
    drive(1'b0, 1'b1, 8'h00);
    #1;
    check("pre_rst_out0_val", out0_val, 1);
    check("pre_rst_out1_val", out1_val, 1);
    check("pre_rst_in_rdy", in_rdy, 1);
    reset = 1'b1;
    #1;
    check("arst_out0_val", out0_val, 0);
    check("arst_out1_val", out1_val, 0);
    check("arst_in_rdy", in_rdy, 0);
    check("arst_out1_count", out1_count, 0);
    check("arst_w_out1_count", w_out1_count, 0);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    drive(1'b1, 1'b1, 8'h5A);
    #1;
    check("arst_release_in_rdy", in_rdy, 1);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    check("arst_first_out1_val", out1_val, 1);
    check("arst_first_out1_msg", out1_msg, 8'h5A);
    check("arst_out0_empty", out0_val, 0);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom % 2), 8'($urandom));
      out0_rdy = ($urandom % 3) != 0;
      out1_rdy = ($urandom % 3) != 0;
      if (($urandom % 500) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      cyc();
    end
    drive(1'b0, 1'b0, 8'h00);
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
